load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage placed directly downstream of the control unit. It consumes the decoded MemWrite / MemtoReg / LoadOrStoreTYPE controls, the ALU-computed address and rs2. It runs one valid/ready transaction on the data-memory port with byte-lane steering, and returns sign- or zero-extended load data to writeback. While a transaction is outstanding it holds the pipeline with Stall.

## Interface
Parameters:
- ADDR_W, 32, address width. Data path is fixed at 32 bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- MemWrite  in  1  store request from control
- MemRead  in  1  load request (control MemtoReg)
- LoadOrStoreTYPE  in  3  funct3 access type
- Addr  in  ADDR_W  byte address from the ALU
- StoreData  in  32  rs2 value
- Stall  out  1  hold the pipeline
- LoadData  out  32  extended load result
- LoadValid  out  1  one-cycle pulse: LoadData is valid
- Fault  out  1  one-cycle pulse: misaligned access or illegal funct3
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts the request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address ({Addr[ADDR_W-1:2],2'b00})
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rsp_valid  in  1  response / write acknowledge
- mem_rdata  in  32  read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If MemWrite or MemRead is asserted, the fields are latched. MemWrite wins if both are asserted.
  - Legal access: go to REQ.
  - Illegal access: pulse Fault for that cycle, issue no bus op, stay IDLE.
  - funct3 legality: loads accept 000, 001, 010, 100, 101. Stores accept 000, 001, 010. Anything else is illegal.
  - Alignment: halfword ops need Addr[0]=0. Word ops need Addr[1:0]=0.
- REQ: mem_req_valid=1 with stable mem_we, mem_addr, mem_wstrb and mem_wdata. Move to WAIT on mem_req_ready.
- WAIT: on mem_rsp_valid, capture the result and move to DONE. Stores also wait for the acknowledge.
- DONE: pulse LoadValid for loads only. Go to IDLE next cycle. Request inputs are ignored in this state.
- Store lane steering:
  - SB: wdata={4{d[7:0]}}, wstrb=0001<<Addr[1:0].
  - SH: wdata={2{d[15:0]}}, wstrb=0011<<(2·Addr[1]).
  - SW: wdata=d, wstrb=1111.
- Load extraction: shift rdata right by 8·Addr[1:0].
  - LB and LH sign-extend from bit 7 and bit 15.
  - LBU and LHU zero-extend.
  - LW passes through.
- Stall:
  - High combinationally when IDLE sees a legal request.
  - High throughout REQ and WAIT.
  - Low in DONE, so the pipeline advances exactly once.
- mem_rsp_valid is ignored outside WAIT.

## Timing
- Reset values: state=IDLE; Stall, LoadValid, Fault, mem_req_valid, mem_we = 0; LoadData, mem_addr, mem_wstrb, mem_wdata = 0.
- Minimum latency with ready=1 and the response one cycle after acceptance:
  - cycle 0: IDLE accepts.
  - cycle 1: REQ handshake.
  - cycle 2: WAIT captures the response.
  - cycle 3: DONE, LoadValid=1, Stall=0.
  - Total: 4 cycles per access.
- The response must arrive at least one cycle after the request handshake. A response in the handshake cycle is dropped.
- Back-pressure: mem_req_valid and the payload hold unchanged until ready.
- Fault costs 1 cycle with Stall=0.
- Reset mid-operation: the FSM drops to IDLE asynchronously and mem_req_valid deasserts immediately. A late response after reset is ignored. Memory-side cleanup is outside this block.
- LoadData holds its value until the next load completes.

## Structure
- Shared package (riscv_pkg):
  - funct3 encodings: LB/LH/LW/LBU/LHU, SB/SH/SW.
  - LSU state encoding.
  - Strobe constants.
- One combinational sub-module, lsu_align:
  - store lane steering plus wstrb generation;
  - load shift and extension;
  - alignment / legality check.
- The FSM and registers stay in load_store_unit.

## Test plan
- SB, Addr=0x1003, StoreData=0x000000A5, ready=1 -> mem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5, mem_we=1, Stall high 3 cycles, no LoadValid.
- LB, Addr=0x2001, rdata=0x12348056 -> LoadData=0x00000080 sign-extended to 0xFFFFFF80. Same access as LBU -> 0x00000080. LoadValid pulse in cycle 3.
- LH, Addr=0x3002, rdata=0xBEEF0000 -> LoadData=0xFFFFBEEF. LW, Addr=0x3001 -> Fault pulse, mem_req_valid never asserted, Stall=0.
- mem_req_ready low for 5 cycles -> mem_req_valid and payload stable, Stall high, handshake completes on the 6th cycle. A response during REQ is ignored.
- reset asserted in WAIT, then mem_rsp_valid -> all outputs 0, state IDLE, no LoadValid. The next LW, Addr=0x4000 completes normally.
- MemWrite and MemRead both high with funct3=010 -> store performed (mem_we=1), no LoadValid. Illegal funct3=011 on a load -> Fault.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: memory funct3 encodings, LSU states, strobes.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_t;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, shift/extend for loads, legality check.
import riscv_pkg::*;

module lsu_align (
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic        legal,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  load_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        legal = 1'b0;
        case (funct3)
            F3_LB:   legal = 1'b1;
            F3_LH:   legal = ~addr_lo[0];
            F3_LW:   legal = (addr_lo == 2'b00);
            F3_LBU:  legal = ~is_store;
            F3_LHU:  legal = ~is_store & ~addr_lo[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        wdata = store_data;
        wstrb = STRB_W;
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                wstrb = STRB_B << addr_lo;
            end
            2'b01: begin
                wdata = {2{store_data[15:0]}};
                wstrb = STRB_H << {addr_lo[1], 1'b0};
            end
            default: begin
                wdata = store_data;
                wstrb = STRB_W;
            end
        endcase
    end

    // Lane of interest is moved to bit 0 before extension
    assign shifted = rdata >> {load_addr_lo, 3'b000};

    always_comb begin
        load_data = shifted;
        case (load_funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'd0, shifted[7:0]};
            F3_LHU:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one valid/ready transaction per load/store,
// holding the pipeline with Stall until the access completes.
import riscv_pkg::*;

module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [2:0]        LoadOrStoreTYPE,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       StoreData,
    output logic              Stall,
    output logic [31:0]       LoadData,
    output logic              LoadValid,
    output logic              Fault,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t  state;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        req;
    logic        legal;
    logic        accept;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] load_data;

    lsu_align u_align (
        .is_store     (MemWrite),
        .funct3       (LoadOrStoreTYPE),
        .addr_lo      (Addr[1:0]),
        .store_data   (StoreData),
        .legal        (legal),
        .wstrb        (wstrb),
        .wdata        (wdata),
        .load_funct3  (funct3_q),
        .load_addr_lo (addr_lo_q),
        .rdata        (mem_rdata),
        .load_data    (load_data)
    );

    assign req    = MemWrite | MemRead;
    assign accept = (state == ST_IDLE) & req & legal;
    assign Fault  = (state == ST_IDLE) & req & ~legal;
    assign Stall  = accept | (state == ST_REQ) | (state == ST_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            funct3_q      <= 3'd0;
            addr_lo_q     <= 2'd0;
            LoadData      <= 32'd0;
            LoadValid     <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wstrb     <= 4'd0;
            mem_wdata     <= 32'd0;
        end else begin
            LoadValid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state         <= ST_REQ;
                        funct3_q      <= LoadOrStoreTYPE;
                        addr_lo_q     <= Addr[1:0];
                        mem_req_valid <= 1'b1;
                        mem_we        <= MemWrite;
                        mem_addr      <= {Addr[ADDR_W-1:2], 2'b00};
                        mem_wstrb     <= MemWrite ? wstrb : 4'd0;
                        mem_wdata     <= MemWrite ? wdata : 32'd0;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Stores complete on the write acknowledge as well
                    if (mem_rsp_valid) begin
                        if (!mem_we) begin
                            LoadData  <= load_data;
                            LoadValid <= 1'b1;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  LoadOrStoreTYPE;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic        Stall;
    logic [31:0] LoadData;
    logic        LoadValid;
    logic        Fault;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .MemWrite        (MemWrite),
        .MemRead         (MemRead),
        .LoadOrStoreTYPE (LoadOrStoreTYPE),
        .Addr            (Addr),
        .StoreData       (StoreData),
        .Stall           (Stall),
        .LoadData        (LoadData),
        .LoadValid       (LoadValid),
        .Fault           (Fault),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wstrb       (mem_wstrb),
        .mem_wdata       (mem_wdata),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rdata       (mem_rdata)
    );

    // Stimulus only: drives one access at minimum latency, returns observations
    task automatic run_access(
        input  logic        w,
        input  logic        r,
        input  logic [2:0]  f3,
        input  logic [31:0] a,
        input  logic [31:0] sd,
        input  logic [31:0] rd,
        output logic [31:0] o_addr,
        output logic [31:0] o_wdata,
        output logic [3:0]  o_strb,
        output logic        o_we,
        output logic        o_lv,
        output logic [31:0] o_ld,
        output int          stalls
    );
        @(posedge clk); #1;
        MemWrite = w; MemRead = r; LoadOrStoreTYPE = f3;
        Addr = a; StoreData = sd; mem_rdata = rd;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
        #1 stalls = int'(Stall);
        @(posedge clk); #1;
        MemWrite = 1'b0; MemRead = 1'b0;
        #1;
        o_addr = mem_addr; o_wdata = mem_wdata;
        o_strb = mem_wstrb; o_we = mem_we;
        stalls += int'(Stall);
        @(posedge clk); #1 mem_rsp_valid = 1'b1;
        #1 stalls += int'(Stall);
        @(posedge clk); #1 mem_rsp_valid = 1'b0;
        #1;
        o_lv = LoadValid; o_ld = LoadData;
        stalls += int'(Stall);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        MemWrite = 0; MemRead = 0; LoadOrStoreTYPE = 0; Addr = 0; StoreData = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({Stall, LoadValid, Fault, mem_req_valid, mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {Stall, LoadValid, Fault, mem_req_valid, mem_we});
        end
        checks++;
        if ({LoadData, mem_addr, mem_wstrb, mem_wdata} !== 100'd0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h want zeros",
                     LoadData, mem_addr, mem_wstrb, mem_wdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_store_byte();
        logic [31:0] ad, wd, ld;
        logic [3:0]  st;
        logic        we, lv;
        int          sc;
        run_access(1, 0, 3'b000, 32'h1003, 32'h000000A5, 32'h0,
                   ad, wd, st, we, lv, ld, sc);
        checks++;
        if (ad !== 32'h1000) begin
            errors++; $display("FAIL sb_addr got %h want 00001000", ad);
        end
        checks++;
        if (st !== 4'b1000 || wd !== 32'hA5A5A5A5 || we !== 1'b1) begin
            errors++;
            $display("FAIL sb_lanes got strb=%b wd=%h we=%b want 1000 a5a5a5a5 1",
                     st, wd, we);
        end
        checks++;
        if (sc != 3 || lv !== 1'b0) begin
            errors++; $display("FAIL sb_timing got stall=%0d lv=%b want 3 0", sc, lv);
        end
    endtask

    task automatic test_store_half();
        logic [31:0] ad, wd, ld;
        logic [3:0]  st;
        logic        we, lv;
        int          sc;
        run_access(1, 0, 3'b001, 32'h2006, 32'h1234ABCD, 32'h0,
                   ad, wd, st, we, lv, ld, sc);
        checks++;
        if (ad !== 32'h2004 || st !== 4'b1100 || wd !== 32'hABCDABCD) begin
            errors++;
            $display("FAIL sh_lanes got %h %b %h want 00002004 1100 abcdabcd",
                     ad, st, wd);
        end
    endtask

    task automatic test_loads();
        logic [31:0] ad, wd, ld;
        logic [3:0]  st;
        logic        we, lv;
        int          sc;
        run_access(0, 1, 3'b000, 32'h2001, 32'h0, 32'h12348056,
                   ad, wd, st, we, lv, ld, sc);
        checks++;
        if (ld !== 32'hFFFFFF80 || lv !== 1'b1 || sc != 3 || we !== 1'b0) begin
            errors++;
            $display("FAIL lb got ld=%h lv=%b st=%0d we=%b want ffffff80 1 3 0",
                     ld, lv, sc, we);
        end
        checks++;
        if (ad !== 32'h2000) begin
            errors++; $display("FAIL lb_addr got %h want 00002000", ad);
        end
        run_access(0, 1, 3'b100, 32'h2001, 32'h0, 32'h12348056,
                   ad, wd, st, we, lv, ld, sc);
        checks++;
        if (ld !== 32'h00000080 || lv !== 1'b1) begin
            errors++; $display("FAIL lbu got ld=%h lv=%b want 00000080 1", ld, lv);
        end
        run_access(0, 1, 3'b001, 32'h3002, 32'h0, 32'hBEEF0000,
                   ad, wd, st, we, lv, ld, sc);
        checks++;
        if (ld !== 32'hFFFFBEEF) begin
            errors++; $display("FAIL lh got %h want ffffbeef", ld);
        end
        run_access(0, 1, 3'b101, 32'h3002, 32'h0, 32'hBEEF0000,
                   ad, wd, st, we, lv, ld, sc);
        checks++;
        if (ld !== 32'h0000BEEF) begin
            errors++; $display("FAIL lhu got %h want 0000beef", ld);
        end
        @(posedge clk); #2;
        checks++;
        if (LoadValid !== 1'b0 || LoadData !== 32'h0000BEEF) begin
            errors++;
            $display("FAIL ld_hold got lv=%b ld=%h want 0 0000beef", LoadValid, LoadData);
        end
    endtask

    task automatic test_fault();
        logic [2:0]  f3s [3] = '{3'b010, 3'b011, 3'b100};
        logic        ws  [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] as  [3] = '{32'h3001, 32'h3000, 32'h3000};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            MemWrite = ws[i]; MemRead = ~ws[i];
            LoadOrStoreTYPE = f3s[i]; Addr = as[i];
            #1;
            checks++;
            if (Fault !== 1'b1 || Stall !== 1'b0) begin
                errors++;
                $display("FAIL fault_%0d got fault=%b stall=%b want 1 0", i, Fault, Stall);
            end
            @(posedge clk); #1;
            MemWrite = 0; MemRead = 0;
            #1;
            checks++;
            if (mem_req_valid !== 1'b0 || Fault !== 1'b0 || Stall !== 1'b0) begin
                errors++;
                $display("FAIL fault_idle_%0d got v=%b f=%b s=%b want 0 0 0",
                         i, mem_req_valid, Fault, Stall);
            end
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        @(posedge clk); #1;
        MemWrite = 0; MemRead = 1; LoadOrStoreTYPE = 3'b010;
        Addr = 32'h5000; mem_req_ready = 0; mem_rsp_valid = 0;
        @(posedge clk); #1;
        MemRead = 0;
        mem_rsp_valid = 1; mem_rdata = 32'h0BAD0BAD;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h5000 ||
                mem_we !== 1'b0 || Stall !== 1'b1)
                bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad);
        end
        // 6th REQ cycle: handshake, with a same-cycle response that must be dropped
        mem_req_ready = 1; mem_rsp_valid = 1;
        @(posedge clk); #1;
        mem_rsp_valid = 0; mem_rdata = 32'hCAFEF00D;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || Stall !== 1'b1 || LoadValid !== 1'b0) begin
            errors++;
            $display("FAIL bp_wait got v=%b s=%b lv=%b want 0 1 0",
                     mem_req_valid, Stall, LoadValid);
        end
        @(posedge clk); #1;
        mem_rsp_valid = 1;
        @(posedge clk); #1;
        mem_rsp_valid = 0;
        #1;
        checks++;
        if (LoadValid !== 1'b1 || LoadData !== 32'hCAFEF00D || Stall !== 1'b0) begin
            errors++;
            $display("FAIL bp_done got lv=%b ld=%h s=%b want 1 cafef00d 0",
                     LoadValid, LoadData, Stall);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ad, wd, ld;
        logic [3:0]  st;
        logic        we, lv;
        int          sc;
        int          lvs = 0;
        @(posedge clk); #1;
        MemRead = 1; LoadOrStoreTYPE = 3'b010; Addr = 32'h7000;
        mem_req_ready = 1; mem_rsp_valid = 0;
        @(posedge clk); #1;
        MemRead = 0;
        @(posedge clk); #1;
        reset = 1;
        #1;
        checks++;
        if ({Stall, LoadValid, mem_req_valid, mem_we, LoadData, mem_addr} !== 68'd0) begin
            errors++;
            $display("FAIL rst_mid got s=%b v=%b ld=%h a=%h want zeros",
                     Stall, mem_req_valid, LoadData, mem_addr);
        end
        @(posedge clk); #1;
        reset = 0; mem_rsp_valid = 1; mem_rdata = 32'h99999999;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_rsp_valid = 0;
            if (LoadValid === 1'b1 || Stall !== 1'b0) lvs++;
        end
        checks++;
        if (lvs != 0) begin
            errors++; $display("FAIL rst_late got %0d bad cycles want 0", lvs);
        end
        run_access(0, 1, 3'b010, 32'h4000, 32'h0, 32'h11223344,
                   ad, wd, st, we, lv, ld, sc);
        checks++;
        if (ld !== 32'h11223344 || lv !== 1'b1 || ad !== 32'h4000 || sc != 3) begin
            errors++;
            $display("FAIL rst_next got ld=%h lv=%b a=%h s=%0d want 11223344 1 4000 3",
                     ld, lv, ad, sc);
        end
    endtask

    task automatic test_both();
        logic [31:0] ad, wd, ld;
        logic [3:0]  st;
        logic        we, lv;
        int          sc;
        run_access(1, 1, 3'b010, 32'h6000, 32'hDEADBEEF, 32'h0,
                   ad, wd, st, we, lv, ld, sc);
        checks++;
        if (we !== 1'b1 || st !== 4'b1111 || wd !== 32'hDEADBEEF || lv !== 1'b0) begin
            errors++;
            $display("FAIL both got we=%b st=%b wd=%h lv=%b want 1 1111 deadbeef 0",
                     we, st, wd, lv);
        end
        checks++;
        if (ld !== 32'h11223344) begin
            errors++; $display("FAIL both_hold got %h want 11223344", ld);
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_store_half();
        test_loads();
        test_fault();
        test_backpressure();
        test_reset_mid();
        test_both();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
